// File: rtl/record_cache_pkg.sv
// Shared definitions for record_cache: bridge direction encodings, widths,
// FSM state encoding and the latched request payload.
package record_cache_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 64;

  localparam logic BR_READ  = 1'b1;
  localparam logic BR_WRITE = 1'b0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB_REQ  = 3'd1,
    WB_WAIT = 3'd2,
    RD_REQ  = 3'd3,
    RD_WAIT = 3'd4,
    RESP    = 3'd5
  } state_t;

  // Client request captured at acceptance.
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/record_cache.sv
// record_cache: single-line write-back cache for 64-bit records in front of
// a one-command-at-a-time bridge.
// Ports:
//   clk, rst                      clock, async active-high reset
//   req_valid/req_ready           client request handshake
//   req_wr, req_addr, req_wdata   request payload
//   rsp_valid, rsp_rdata          one-cycle response pulse and data
//   C_in_valid, C_r_wb, C_addr,
//   C_data_w                      one-cycle bridge command
//   C_out_valid, C_data_r         bridge completion and read data
// Optional feature macro RECORD_CACHE_FLUSH_EN adds flush_req / flush_done.
module record_cache
  import record_cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              C_in_valid,
  output logic              C_r_wb,
  output logic [ADDR_W-1:0] C_addr,
  output logic [DATA_W-1:0] C_data_w,
  input  logic              C_out_valid,
  input  logic [DATA_W-1:0] C_data_r
`ifdef RECORD_CACHE_FLUSH_EN
  ,
  input  logic              flush_req,
  output logic              flush_done
`endif
);

  state_t            state_q, state_d;
  req_t              req_q, req_d;
  logic [DATA_W-1:0] line_data_q, line_data_d;
  logic [ADDR_W-1:0] line_tag_q, line_tag_d;
  logic              line_valid_q, line_valid_d;
  logic              line_dirty_q, line_dirty_d;

  logic              ready_q, ready_d;
  logic              rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_d;
  logic              c_in_valid_d;
  logic              c_r_wb_d;
  logic [ADDR_W-1:0] c_addr_d;
  logic [DATA_W-1:0] c_data_w_d;
  logic              hit;

`ifdef RECORD_CACHE_FLUSH_EN
  logic flushing_q, flushing_d;
  logic flush_done_d;
`endif

  assign hit = line_valid_q && (line_tag_q == req_addr);

  // State, line and registered-output update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      req_q        <= '0;
      line_data_q  <= '0;
      line_tag_q   <= '0;
      line_valid_q <= 1'b0;
      line_dirty_q <= 1'b0;
      ready_q      <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      C_in_valid   <= 1'b0;
      C_r_wb       <= BR_READ;
      C_addr       <= '0;
      C_data_w     <= '0;
`ifdef RECORD_CACHE_FLUSH_EN
      flushing_q   <= 1'b0;
      flush_done   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      line_data_q  <= line_data_d;
      line_tag_q   <= line_tag_d;
      line_valid_q <= line_valid_d;
      line_dirty_q <= line_dirty_d;
      ready_q      <= ready_d;
      rsp_valid    <= rsp_valid_d;
      rsp_rdata    <= rsp_rdata_d;
      C_in_valid   <= c_in_valid_d;
      C_r_wb       <= c_r_wb_d;
      C_addr       <= c_addr_d;
      C_data_w     <= c_data_w_d;
`ifdef RECORD_CACHE_FLUSH_EN
      flushing_q   <= flushing_d;
      flush_done   <= flush_done_d;
`endif
    end
  end

  // Next-state, line update and next output values.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    line_data_d  = line_data_q;
    line_tag_d   = line_tag_q;
    line_valid_d = line_valid_q;
    line_dirty_d = line_dirty_q;
    rsp_rdata_d  = '0;
`ifdef RECORD_CACHE_FLUSH_EN
    flushing_d   = flushing_q;
    flush_done_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
`ifdef RECORD_CACHE_FLUSH_EN
        if (flush_req) begin
          if (line_valid_q && line_dirty_q) begin
            flushing_d = 1'b1;
            state_d    = WB_REQ;
          end else begin
            line_valid_d = 1'b0;
            line_dirty_d = 1'b0;
            flush_done_d = 1'b1;
          end
        end else
`endif
        if (req_valid) begin
          req_d.wr    = req_wr;
          req_d.addr  = req_addr;
          req_d.wdata = req_wdata;
          if (hit) begin
            state_d = RESP;
            if (req_wr) begin
              line_data_d  = req_wdata;
              line_dirty_d = 1'b1;
              rsp_rdata_d  = req_wdata;
            end else begin
              rsp_rdata_d  = line_data_q;
            end
          end else if (line_valid_q && line_dirty_q) begin
            state_d = WB_REQ;
          end else if (req_wr) begin
            // Whole record is overwritten, so no fill read is needed.
            line_data_d  = req_wdata;
            line_tag_d   = req_addr;
            line_valid_d = 1'b1;
            line_dirty_d = 1'b1;
            rsp_rdata_d  = req_wdata;
            state_d      = RESP;
          end else begin
            state_d = RD_REQ;
          end
        end
      end
      WB_REQ: state_d = WB_WAIT;
      WB_WAIT: begin
        if (C_out_valid) begin
          line_dirty_d = 1'b0;
`ifdef RECORD_CACHE_FLUSH_EN
          if (flushing_q) begin
            flushing_d   = 1'b0;
            line_valid_d = 1'b0;
            flush_done_d = 1'b1;
            state_d      = IDLE;
          end else
`endif
          if (req_q.wr) begin
            line_data_d  = req_q.wdata;
            line_tag_d   = req_q.addr;
            line_valid_d = 1'b1;
            line_dirty_d = 1'b1;
            rsp_rdata_d  = req_q.wdata;
            state_d      = RESP;
          end else begin
            state_d = RD_REQ;
          end
        end
      end
      RD_REQ: state_d = RD_WAIT;
      RD_WAIT: begin
        if (C_out_valid) begin
          line_data_d  = C_data_r;
          line_tag_d   = req_q.addr;
          line_valid_d = 1'b1;
          line_dirty_d = 1'b0;
          rsp_rdata_d  = C_data_r;
          state_d      = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so derive them from the state being entered.
    ready_d      = (state_d == IDLE);
    rsp_valid_d  = (state_d == RESP);
    c_in_valid_d = (state_d == WB_REQ) || (state_d == RD_REQ);
    c_r_wb_d     = (state_d == WB_REQ) ? BR_WRITE : BR_READ;
    c_addr_d     = '0;
    c_data_w_d   = '0;
    if (state_d == WB_REQ) begin
      // Line is untouched on the way into WB_REQ, so it still holds the victim.
      c_addr_d   = line_tag_q;
      c_data_w_d = line_data_q;
    end else if (state_d == RD_REQ) begin
      c_addr_d   = req_d.addr;
    end
  end

`ifdef RECORD_CACHE_FLUSH_EN
  // A flush request in IDLE takes the slot, so no client request that cycle.
  assign req_ready = ready_q && !flush_req;
`else
  assign req_ready = ready_q;
`endif

endmodule

// File: tb/tb_record_cache.sv
// Self-checking bench for record_cache: table of request vectors with the
// expected bridge traffic and response, plus hand-written reset and flush
// sequences. Define RECORD_CACHE_FLUSH_EN to exercise the flush ports.
module tb_record_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [7:0]  req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        C_in_valid;
  logic        C_r_wb;
  logic [7:0]  C_addr;
  logic [63:0] C_data_w;
  logic        C_out_valid;
  logic [63:0] C_data_r;
`ifdef RECORD_CACHE_FLUSH_EN
  logic        flush_req;
  logic        flush_done;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [63:0] JUNK = 64'hBADB_ADBA_DBAD_BADB;

  always #5 clk = ~clk;

  record_cache dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .C_in_valid(C_in_valid), .C_r_wb(C_r_wb), .C_addr(C_addr),
    .C_data_w(C_data_w), .C_out_valid(C_out_valid), .C_data_r(C_data_r)
`ifdef RECORD_CACHE_FLUSH_EN
    , .flush_req(flush_req), .flush_done(flush_done)
`endif
  );

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [63:0] wdata;
    logic        exp_wb;
    logic [7:0]  wb_addr;
    logic [63:0] wb_data;
    logic        exp_rd;
    logic [63:0] br_rdata;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, act as bridge (completion 2 cycles after a command)
  // and check the commands seen and the response.
  task automatic run_vec(input string tag, input vec_t v);
    logic        c_rwb[2];
    logic [7:0]  c_addr[2];
    logic [63:0] c_dat[2];
    int          ncmd = 0;
    int          wait_cnt = 0;
    logic        last_rwb = 1'b1;
    logic        got = 1'b0;
    logic        bus_bad = 1'b0;
    int          lat = 0;
    logic [63:0] rdata = '0;
    int          k;
    int          tries = 0;

    while (!req_ready && tries < 10) begin
      tick();
      tries++;
    end
    chk({tag, "_ready"}, 64'(req_ready), 64'd1);

    req_valid = 1'b1; req_wr = v.wr; req_addr = v.addr; req_wdata = v.wdata;
    tick();
    req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;

    for (int c = 1; c <= 40; c++) begin
      C_out_valid = 1'b0;
      C_data_r    = '0;
      if (!C_in_valid && (C_addr !== 8'd0 || C_data_w !== 64'd0)) bus_bad = 1'b1;
      if (C_in_valid) begin
        if (ncmd < 2) begin
          c_rwb[ncmd] = C_r_wb; c_addr[ncmd] = C_addr; c_dat[ncmd] = C_data_w;
        end
        ncmd++;
        last_rwb = C_r_wb;
        wait_cnt = 2;
      end else if (wait_cnt > 0) begin
        wait_cnt--;
        if (wait_cnt == 0) begin
          C_out_valid = 1'b1;
          C_data_r    = last_rwb ? v.br_rdata : JUNK;
        end
      end
      if (rsp_valid) begin
        got = 1'b1; lat = c; rdata = rsp_rdata;
        break;
      end
      tick();
    end
    C_out_valid = 1'b0;
    C_data_r    = '0;

    chk({tag, "_rsp_seen"}, 64'(got), 64'd1);
    chk({tag, "_rdata"}, rdata, v.exp_rdata);
    chk({tag, "_ncmd"}, 64'(ncmd), 64'(32'(v.exp_wb) + 32'(v.exp_rd)));
    chk({tag, "_idle_bus_zero"}, 64'(bus_bad), 64'd0);
    k = 0;
    if (v.exp_wb && ncmd > 0) begin
      chk({tag, "_wb_dir"}, 64'(c_rwb[0]), 64'd0);
      chk({tag, "_wb_addr"}, 64'(c_addr[0]), 64'(v.wb_addr));
      chk({tag, "_wb_data"}, c_dat[0], v.wb_data);
      k = 1;
    end
    if (v.exp_rd && ncmd > k) begin
      chk({tag, "_rd_dir"}, 64'(c_rwb[k]), 64'd1);
      chk({tag, "_rd_addr"}, 64'(c_addr[k]), 64'(v.addr));
      chk({tag, "_rd_wdata_zero"}, c_dat[k], 64'd0);
    end
    if (!v.exp_wb && !v.exp_rd) chk({tag, "_hit_latency"}, 64'(lat), 64'd1);
    tick();
    chk({tag, "_rsp_one_cycle"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_back_idle"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    int bad;

    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    C_out_valid = 1'b0; C_data_r = '0;
`ifdef RECORD_CACHE_FLUSH_EN
    flush_req = 1'b0;
`endif

    //         wr    addr   wdata   wb    wb_addr wb_data  rd    br_rdata                exp_rdata
    vecs[0] = '{1'b0, 8'h12, 64'h0, 1'b0, 8'h00, 64'h0,   1'b1, 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001};
    vecs[1] = '{1'b0, 8'h12, 64'h0, 1'b0, 8'h00, 64'h0,   1'b0, 64'h0,                   64'hDEAD_BEEF_0000_0001};
    vecs[2] = '{1'b1, 8'h12, 64'h55,1'b0, 8'h00, 64'h0,   1'b0, 64'h0,                   64'h55};
    vecs[3] = '{1'b0, 8'h34, 64'h0, 1'b1, 8'h12, 64'h55,  1'b1, 64'h3434_0000_0000_3434, 64'h3434_0000_0000_3434};
    vecs[4] = '{1'b1, 8'h40, 64'hAA,1'b0, 8'h00, 64'h0,   1'b0, 64'h0,                   64'hAA};
    vecs[5] = '{1'b0, 8'h41, 64'h0, 1'b1, 8'h40, 64'hAA,  1'b1, 64'h4141_4141,           64'h4141_4141};
    vecs[6] = '{1'b1, 8'h41, 64'h77,1'b0, 8'h00, 64'h0,   1'b0, 64'h0,                   64'h77};
    vecs[7] = '{1'b1, 8'h50, 64'h99,1'b1, 8'h41, 64'h77,  1'b0, 64'h0,                   64'h99};
    vecs[8] = '{1'b0, 8'h50, 64'h0, 1'b0, 8'h00, 64'h0,   1'b0, 64'h0,                   64'h99};
    vecs[9] = '{1'b0, 8'h12, 64'h0, 1'b1, 8'h50, 64'h99,  1'b1, 64'h1212_1212_1212_1212, 64'h1212_1212_1212_1212};

    // Reset values.
    tick(); tick();
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", rsp_rdata, 64'd0);
    chk("rst_c_in_valid", 64'(C_in_valid), 64'd0);
    chk("rst_c_addr", 64'(C_addr), 64'd0);
    chk("rst_c_data_w", C_data_w, 64'd0);
    rst = 1'b0;
    tick();
    chk("rst_release_ready", 64'(req_ready), 64'd1);

    for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Reset while waiting for a fill; a late completion must be ignored.
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 8'h66;
    tick();
    req_valid = 1'b0; req_addr = '0;
    chk("rstmid_rd_cmd", 64'(C_in_valid), 64'd1);
    chk("rstmid_rd_addr", 64'(C_addr), 64'h66);
    tick();
    chk("rstmid_in_wait", 64'(C_in_valid), 64'd0);
    rst = 1'b1;
    #1;
    chk("rstmid_ready_in_rst", 64'(req_ready), 64'd1);
    tick();
    rst = 1'b0;
    C_out_valid = 1'b1; C_data_r = JUNK;
    tick();
    C_out_valid = 1'b0; C_data_r = '0;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (rsp_valid || C_in_valid) bad++;
      tick();
    end
    chk("rstmid_stray_ignored", 64'(bad), 64'd0);
    run_vec("rstmid_refill", '{1'b0, 8'h12, 64'h0, 1'b0, 8'h00, 64'h0,
                               1'b1, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF});

`ifdef RECORD_CACHE_FLUSH_EN
    // Dirty line 0x40 is written back by a flush, then invalidated.
    run_vec("fl_write", '{1'b1, 8'h40, 64'hAA, 1'b0, 8'h00, 64'h0, 1'b0, 64'h0, 64'hAA});
    flush_req = 1'b1; req_valid = 1'b1; req_addr = 8'h40;
    #1;
    chk("fl_ready_blocked", 64'(req_ready), 64'd0);
    tick();
    flush_req = 1'b0; req_valid = 1'b0; req_addr = '0;
    chk("fl_wb_cmd", 64'(C_in_valid), 64'd1);
    chk("fl_wb_dir", 64'(C_r_wb), 64'd0);
    chk("fl_wb_addr", 64'(C_addr), 64'h40);
    chk("fl_wb_data", C_data_w, 64'hAA);
    tick();
    C_out_valid = 1'b1; C_data_r = JUNK;
    chk("fl_done_early", 64'(flush_done), 64'd0);
    tick();
    C_out_valid = 1'b0; C_data_r = '0;
    chk("fl_done", 64'(flush_done), 64'd1);
    chk("fl_no_rsp", 64'(rsp_valid), 64'd0);
    tick();
    chk("fl_done_pulse", 64'(flush_done), 64'd0);
    run_vec("fl_read_miss", '{1'b0, 8'h40, 64'h0, 1'b0, 8'h00, 64'h0,
                              1'b1, 64'h4040_4040, 64'h4040_4040});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
